mpu_bus_master: RTL

MPU_BUS_MASTER -- requirements
Module: mpu_bus_master

---
 rtl/mpu_bus_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mpu_bus_master.sv
// MPU bus master: runs one request/response transaction at a time as a timed
// setup / strobe / hold cycle on an asynchronous-style MPU bus.
module mpu_bus_master #(
  parameter int unsigned ADDR_WIDTH    = 17,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  _mpu_en,
  output logic                  _mpu_rd,
  output logic                  _mpu_wr,
  output logic [1:0]            _mpu_be,
  output logic [ADDR_WIDTH-1:0] mpu_addr,
  inout  wire  [DATA_WIDTH-1:0] mpu_data
);

  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   phase_cnt;
  logic                   write_q;
  logic                   active_q;
  logic                   drive_q;
  logic [DATA_WIDTH-1:0]  wdata_q;

  // Write data is driven from SETUP through HOLD; reads and idle leave the bus floating.
  assign mpu_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

  // Phase counter counts down the remaining cycles of the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      write_q   <= 1'b0;
      active_q  <= 1'b0;
      drive_q   <= 1'b0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      _mpu_en   <= 1'b1;
      _mpu_rd   <= 1'b1;
      _mpu_wr   <= 1'b1;
      _mpu_be   <= 2'b11;
      mpu_addr  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= SETUP;
            phase_cnt <= SETUP_LOAD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            write_q   <= req_write;
            wdata_q   <= req_wdata;
            active_q  <= |req_be;
            drive_q   <= req_write & (|req_be);
            mpu_addr  <= req_addr;
            _mpu_be   <= ~req_be;
            _mpu_en   <= ~(|req_be);
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (phase_cnt == '0) begin
            state     <= STROBE;
            phase_cnt <= STROBE_LOAD;
            _mpu_rd   <= ~(active_q & ~write_q);
            _mpu_wr   <= ~(active_q & write_q);
          end else begin
            phase_cnt <= phase_cnt - CNT_WIDTH'(1);
          end
        end
        STROBE: begin
          if (phase_cnt == '0) begin
            state     <= HOLD;
            phase_cnt <= HOLD_LOAD;
            _mpu_rd   <= 1'b1;
            _mpu_wr   <= 1'b1;
            if (active_q && !write_q) begin
              rsp_rdata <= mpu_data;
            end
          end else begin
            phase_cnt <= phase_cnt - CNT_WIDTH'(1);
          end
        end
        HOLD: begin
          if (phase_cnt == '0) begin
            state     <= IDLE;
            phase_cnt <= '0;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            drive_q   <= 1'b0;
            _mpu_en   <= 1'b1;
            _mpu_be   <= 2'b11;
          end else begin
            phase_cnt <= phase_cnt - CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
